switches_pio_in: RTL
====================

Name: switches_pio_in

Overview:
- Avalon-MM slave input port that samples board switches (asynchronous, bouncy inputs) for the Nios system.
- Synchronizes and debounces each bit, then exposes the stable value as a readable register.
- Captures edges into a sticky register and raises a maskable interrupt to the CPU.
- Counterpart of the output PIO: CPU reads the port here instead of writing it.

Parameters:
- WIDTH, 8, number of switch inputs (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable clocks required before a bit change is accepted (>=1).
- EDGE_TYPE, 0, edge capture type: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- in_port, input, WIDTH, raw switch inputs, asynchronous to clk.
- readdata, output, 32, read data, zero-extended.
- irq, output, 1, interrupt request, active-high, level.

Behaviour:
- Clock and reset:
  - Clock clk; reset reset_n, asynchronous, active-low.
  - On reset, all of the following clear to 0: sync stages, debounce counters, stable value, irq_mask, edge_capture.
  - With all of those at 0, readdata = 0 and irq = 0.
  - Reset asserted mid-count discards partial debounce progress.
- Synchronizer: two flops per bit (sync1 <= in_port, sync2 <= sync1).
- Debounce, per bit, with a counter of clog2(DEBOUNCE_CYCLES+1) bits:
  - If sync2 == stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, stable <= sync2 and the counter clears.
  - A bounce back to the old value before that point clears the counter and leaves stable unchanged.
  - Latency from in_port change to stable change: exactly DEBOUNCE_CYCLES+2 rising edges.
- Edge detect:
  - Registered previous value stable_d (reset 0).
  - Rising = stable & ~stable_d; falling = ~stable & stable_d; any = stable ^ stable_d, selected by EDGE_TYPE.
  - A switch held high through reset produces one rising-edge capture after DEBOUNCE_CYCLES+2 clocks. This is intended behaviour; irq_mask = 0 after reset keeps it silent.
- Register map (read latency 0; readdata is a combinational mux of registers, qualified by address only):
  - 0 DATA (RO): {zeros, stable}. Writes are ignored.
  - 1 IRQ_MASK (RW): bits [WIDTH-1:0] are writable. Written when chipselect && ~write_n && address == 1.
  - 2: reads 0; writes ignored.
  - 3 EDGE_CAPTURE (R/W1C): bit sets on a detected edge and stays set until written with 1.
- Write/edge collision on EDGE_CAPTURE: same-cycle write-1 clear and new edge on the same bit -> the bit remains set (set wins).
- Unused upper readdata bits are always 0. Writedata bits above WIDTH are ignored.
- irq = |(edge_capture & irq_mask), driven combinationally from registers. It asserts the cycle after the capturing edge and deasserts the cycle after the clear or mask write.

Optional Feature:
- Macro SWITCHES_PIO_DEBOUNCE_EN.
- Defined: debounce logic as specified above.
- Undefined:
  - Counters are not built and stable <= sync2 every clock.
  - Input-to-DATA latency is exactly 2 clocks.
  - DEBOUNCE_CYCLES is ignored.
  - Bounces produce multiple edge captures (sticky, so edge_capture is still 1).

Test Plan:
- Reset/idle:
  - Stimulus: assert reset_n=0 with in_port=8'hA5; release, wait 1 clock.
  - Required response: DATA read = 0, irq=0.
  - Then after 18 clocks (DEBOUNCE_CYCLES=16), DATA = 32'h000000A5 and EDGE_CAPTURE = 32'h000000A5 (rising); irq stays 0.
- Debounce reject:
  - Stimulus: from stable 0, toggle in_port[0] high for 10 clocks then low.
  - Required response: DATA bit0 never changes; EDGE_CAPTURE bit0 stays 0.
  - Hold high 16 clocks -> DATA bit0 = 1 exactly 18 clocks after the change.
- Interrupt flow:
  - Stimulus: write IRQ_MASK = 32'h01; produce a debounced rising edge on bit0.
  - Required response: irq=1 the cycle after capture.
  - Write EDGE_CAPTURE = 32'h01 -> irq=0 the next cycle.
  - Writing 32'h02 instead leaves irq=1.
- Set/clear collision: write 1 to EDGE_CAPTURE bit3 in the same cycle bit3's edge is detected -> bit3 reads 1 afterwards.
- Mask gating: edge_capture=8'h10, IRQ_MASK=0 -> irq=0; write IRQ_MASK=32'h10 -> irq=1 the next cycle.
- Address 2 and ignored writes:
  - Address 2 reads 0.
  - Writing 32'hFFFFFFFF to DATA leaves DATA unchanged.
  - Bits above WIDTH in any register read 0.

Source files
------------

// File: rtl/switches_pio_in.sv
// Avalon-MM switch input port: synchronizes and debounces the raw switches, then
// exposes DATA, IRQ_MASK and a sticky EDGE_CAPTURE register. Debounce is built only
// when SWITCHES_PIO_DEBOUNCE_EN is defined; otherwise the synchronized value is used directly.
module switches_pio_in #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : gBadParams
    $error("switches_pio_in: parameter out of range");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stableVal;
  logic [WIDTH-1:0] stablePrev_q;
  logic [WIDTH-1:0] irqMask_q, irqMask_d;
  logic [WIDTH-1:0] edgeCapture_q, edgeCapture_d;
  logic [WIDTH-1:0] edgeDet;
  logic             maskWrite, captureWrite;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCHES_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;

  // A bit is accepted only after it has differed from the stable value for
  // DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stableVal = stable_q;
`else
  assign stableVal = sync2_q;
`endif

  if (EDGE_TYPE == 0) begin : gRise
    assign edgeDet = stableVal & ~stablePrev_q;
  end else if (EDGE_TYPE == 1) begin : gFall
    assign edgeDet = ~stableVal & stablePrev_q;
  end else begin : gAny
    assign edgeDet = stableVal ^ stablePrev_q;
  end

  if (WIDTH < 32) begin : gUnusedWdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign maskWrite    = chipselect && !write_n && (address == 2'd1);
  assign captureWrite = chipselect && !write_n && (address == 2'd3);

  // A new edge in the same cycle as a write-1 clear keeps the bit set.
  always_comb begin
    irqMask_d     = irqMask_q;
    edgeCapture_d = edgeCapture_q;
    if (maskWrite) irqMask_d = writedata[WIDTH-1:0];
    if (captureWrite) edgeCapture_d = edgeCapture_q & ~writedata[WIDTH-1:0];
    edgeCapture_d = edgeCapture_d | edgeDet;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stablePrev_q  <= '0;
      irqMask_q     <= '0;
      edgeCapture_q <= '0;
    end else begin
      stablePrev_q  <= stableVal;
      irqMask_q     <= irqMask_d;
      edgeCapture_q <= edgeCapture_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0:    readdata[WIDTH-1:0] = stableVal;
      2'd1:    readdata[WIDTH-1:0] = irqMask_q;
      2'd3:    readdata[WIDTH-1:0] = edgeCapture_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgeCapture_q & irqMask_q);

endmodule
